// File: rtl/bridge_pkg.sv
// Shared types and constants for the AHB2APB bridge: AHB encodings, address map
// and the state enum shared with bridge_apb_controller.
package bridge_pkg;

    localparam int          WIDTH    = 32;
    localparam int          SLAVES   = 4;
    localparam logic [31:0] CFG_ADDR = 32'h0000_0004;

    // Address map: HADDR[15:12] selects the region, internal space tops out at 0x008
    localparam logic [3:0]  REGION_INTERNAL = 4'h0;
    localparam logic [3:0]  REGION_TIMER    = 4'h1;
    localparam logic [3:0]  REGION_INTC     = 4'h2;
    localparam logic [3:0]  REGION_REMAP    = 4'h3;
    localparam logic [3:0]  REGION_SLAVE4   = 4'h4;
    localparam logic [11:0] INTERNAL_TOP    = 12'h008;

    localparam int FLAG_TIMER  = 0;
    localparam int FLAG_INTC   = 1;
    localparam int FLAG_REMAP  = 2;
    localparam int FLAG_SLAVE4 = 3;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_BUSY   = 2'b01,
        TRANS_NONSEQ = 2'b10,
        TRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        BURST_SINGLE = 3'd0,
        BURST_INCR   = 3'd1,
        BURST_WRAP4  = 3'd2,
        BURST_INCR4  = 3'd3,
        BURST_WRAP8  = 3'd4,
        BURST_INCR8  = 3'd5,
        BURST_WRAP16 = 3'd6,
        BURST_INCR16 = 3'd7
    } hburst_t;

    typedef enum logic [1:0] {
        RESP_OKAY  = 2'b00,
        RESP_ERROR = 2'b01,
        RESP_RETRY = 2'b10,
        RESP_SPLIT = 2'b11
    } hresp_t;

    typedef enum logic [1:0] {
        OKAY = 2'd0,
        ERR1 = 2'd1,
        ERR2 = 2'd2
    } err_state_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_READ     = 3'd1,
        ST_WWAIT    = 3'd2,
        ST_WRITE    = 3'd3,
        ST_WRITEP   = 3'd4,
        ST_WENABLE  = 3'd5,
        ST_WENABLEP = 3'd6,
        ST_RENABLE  = 3'd7
    } apb_state_t;

    // Beats remaining after the first beat of a fixed-length burst
    function automatic logic [3:0] burst_last_beat(input hburst_t burst);
        logic [3:0] beats;
        case (burst)
            BURST_WRAP4,  BURST_INCR4:  beats = 4'd3;
            BURST_WRAP8,  BURST_INCR8:  beats = 4'd7;
            BURST_WRAP16, BURST_INCR16: beats = 4'd15;
            default:                    beats = 4'd0;
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/bridge_burst_addr_gen.sv
// Next-beat address (INCR or WRAP boundary) and remaining-beat counter for
// the transfer currently held in the address-phase registers.
module bridge_burst_addr_gen #(
    parameter int WIDTH = bridge_pkg::WIDTH
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             accept,
    input  logic [1:0]       htrans,
    input  logic [2:0]       hburst,
    input  logic [WIDTH-1:0] addr_d1,
    input  logic [2:0]       size_reg,
    output logic [WIDTH-1:0] inc_addr,
    output logic [3:0]       beats_left
);
    import bridge_pkg::*;

    hburst_t          burst_r;
    logic [3:0]       beats_r;
    logic [WIDTH-1:0] bytes_s;
    logic [WIDTH-1:0] next_s;
    logic [WIDTH-1:0] mask_s;
    logic [WIDTH-1:0] inc_addr_s;

    // Burst type and beat count follow each accepted transfer; NONSEQ restarts the count
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            burst_r <= BURST_SINGLE;
            beats_r <= 4'd0;
        end else if (accept) begin
            burst_r <= hburst_t'(hburst);
            if (htrans == TRANS_NONSEQ) begin
                beats_r <= burst_last_beat(hburst_t'(hburst));
            end else if (beats_r != 4'd0) begin
                beats_r <= beats_r - 4'd1;
            end
        end
    end

    // Wrapping bursts keep the bits above the wrap block; an all-ones mask gives plain increment
    always_comb begin
        bytes_s = WIDTH'(1'b1) << size_reg;
        next_s  = addr_d1 + bytes_s;
        case (burst_r)
            BURST_WRAP4:  mask_s = (bytes_s << 2) - WIDTH'(1'b1);
            BURST_WRAP8:  mask_s = (bytes_s << 3) - WIDTH'(1'b1);
            BURST_WRAP16: mask_s = (bytes_s << 4) - WIDTH'(1'b1);
            default:      mask_s = {WIDTH{1'b1}};
        endcase
        inc_addr_s = (addr_d1 & ~mask_s) | (next_s & mask_s);
    end

    assign inc_addr   = inc_addr_s;
    assign beats_left = beats_r;

endmodule

// File: rtl/bridge_ahb_slave_if.sv
// AHB-side front end of the AHB2APB bridge: transfer qualification, address/data
// pipeline, APB slave decode, internal config register and ERROR response.
module bridge_ahb_slave_if #(
    parameter int          WIDTH    = bridge_pkg::WIDTH,
    parameter int          SLAVES   = bridge_pkg::SLAVES,
    parameter logic [31:0] CFG_ADDR = bridge_pkg::CFG_ADDR
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             HSEL,
    input  logic [31:0]      HADDR,
    input  logic [1:0]       HTRANS,
    input  logic             HWRITE,
    input  logic [2:0]       HSIZE,
    input  logic [2:0]       HBURST,
    input  logic [WIDTH-1:0] HWDATA,
    input  logic             HREADY_IN,
    output logic             valid,
    output logic             HWRITE_REG,
    output logic [2:0]       HSIZE_REG,
    output logic [WIDTH-1:0] HADDR_REG_D1,
    output logic [WIDTH-1:0] HADDR_REG_D2,
    output logic [WIDTH-1:0] HADDR_REG_D3,
    output logic [WIDTH-1:0] HWDATA_REG,
    output logic [WIDTH-1:0] INC_ADDR,
    output logic [WIDTH-1:0] CONFIG_REG_DATA,
    output logic             flag_timer,
    output logic             flag_interruptc,
    output logic             flag_remap_pause_controller,
    output logic             flag_slave4,
    output logic [3:0]       burst_beats_left,
    output logic [1:0]       HRESP,
    output logic             HREADY_ERR
);
    import bridge_pkg::*;

    logic              accept_s;
    logic              internal_s;
    logic              mapped_s;
    logic              err_start_s;
    logic [SLAVES-1:0] flags_dec_s;

    logic              hwrite_r;
    logic [2:0]        hsize_r;
    logic [WIDTH-1:0]  d1_r;
    logic [WIDTH-1:0]  d2_r;
    logic [WIDTH-1:0]  d3_r;
    logic [WIDTH-1:0]  hwdata_r;
    logic [WIDTH-1:0]  cfg_r;
    logic [SLAVES-1:0] flags_r;
    logic              wr_pend_r;
    logic              cfg_pend_r;
    err_state_t        err_state_r;
    hresp_t            hresp_r;
    logic              hready_err_r;

    assign accept_s    = HSEL & HTRANS[1] & HREADY_IN;
    assign err_start_s = accept_s & ~mapped_s;
    assign valid       = accept_s & mapped_s & (err_state_r != ERR1);

    // Address decode: internal window or one APB slave region, anything else is unmapped
    always_comb begin
        internal_s  = (HADDR[31:12] == 20'h0_0000) && (HADDR[11:0] <= INTERNAL_TOP);
        flags_dec_s = '0;
        case (HADDR[15:12])
            REGION_TIMER:  flags_dec_s[FLAG_TIMER]  = 1'b1;
            REGION_INTC:   flags_dec_s[FLAG_INTC]   = 1'b1;
            REGION_REMAP:  flags_dec_s[FLAG_REMAP]  = 1'b1;
            REGION_SLAVE4: flags_dec_s[FLAG_SLAVE4] = 1'b1;
            default:       flags_dec_s = '0;
        endcase
        mapped_s = internal_s | (|flags_dec_s);
    end

    // Address-phase capture on every accepted transfer
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hwrite_r <= 1'b0;
            hsize_r  <= 3'd0;
            d1_r     <= '0;
            flags_r  <= '0;
        end else if (accept_s) begin
            hwrite_r <= HWRITE;
            hsize_r  <= HSIZE;
            d1_r     <= WIDTH'(HADDR);
            flags_r  <= flags_dec_s;
        end
    end

    // Free-running address delay line for the downstream controller
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            d2_r <= '0;
            d3_r <= '0;
        end else begin
            d2_r <= d1_r;
            d3_r <= d2_r;
        end
    end

    // Data phase: a write accepted last cycle completes once HREADY_IN is high
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hwdata_r   <= '0;
            cfg_r      <= '0;
            wr_pend_r  <= 1'b0;
            cfg_pend_r <= 1'b0;
        end else if (HREADY_IN) begin
            if (wr_pend_r) begin
                hwdata_r <= HWDATA;
            end
            if (cfg_pend_r) begin
                cfg_r <= HWDATA;
            end
            wr_pend_r  <= accept_s & HWRITE;
            cfg_pend_r <= accept_s & HWRITE & (HADDR == CFG_ADDR);
        end
    end

    // Two-cycle ERROR response; ERR2 may chain straight into another ERR1
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            err_state_r  <= OKAY;
            hresp_r      <= RESP_OKAY;
            hready_err_r <= 1'b1;
        end else begin
            case (err_state_r)
                ERR1: begin
                    err_state_r  <= ERR2;
                    hresp_r      <= RESP_ERROR;
                    hready_err_r <= 1'b1;
                end
                OKAY, ERR2: begin
                    if (err_start_s) begin
                        err_state_r  <= ERR1;
                        hresp_r      <= RESP_ERROR;
                        hready_err_r <= 1'b0;
                    end else begin
                        err_state_r  <= OKAY;
                        hresp_r      <= RESP_OKAY;
                        hready_err_r <= 1'b1;
                    end
                end
                default: begin
                    err_state_r  <= OKAY;
                    hresp_r      <= RESP_OKAY;
                    hready_err_r <= 1'b1;
                end
            endcase
        end
    end

    bridge_burst_addr_gen #(
        .WIDTH (WIDTH)
    ) u_burst_addr_gen (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .accept     (accept_s),
        .htrans     (HTRANS),
        .hburst     (HBURST),
        .addr_d1    (d1_r),
        .size_reg   (hsize_r),
        .inc_addr   (INC_ADDR),
        .beats_left (burst_beats_left)
    );

    assign HWRITE_REG                  = hwrite_r;
    assign HSIZE_REG                   = hsize_r;
    assign HADDR_REG_D1                = d1_r;
    assign HADDR_REG_D2                = d2_r;
    assign HADDR_REG_D3                = d3_r;
    assign HWDATA_REG                  = hwdata_r;
    assign CONFIG_REG_DATA             = cfg_r;
    assign flag_timer                  = flags_r[FLAG_TIMER];
    assign flag_interruptc             = flags_r[FLAG_INTC];
    assign flag_remap_pause_controller = flags_r[FLAG_REMAP];
    assign flag_slave4                 = flags_r[FLAG_SLAVE4];
    assign HRESP                       = hresp_r;
    assign HREADY_ERR                  = hready_err_r;

endmodule

// File: tb/tb_bridge_ahb_slave_if.sv
// Self-checking bench for bridge_ahb_slave_if: decode table, directed corner
// sequences and random traffic against a transaction-level reference model.
module tb_bridge_ahb_slave_if;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic        HREADY_IN;
    logic        valid;
    logic        HWRITE_REG;
    logic [2:0]  HSIZE_REG;
    logic [31:0] HADDR_REG_D1, HADDR_REG_D2, HADDR_REG_D3;
    logic [31:0] HWDATA_REG, INC_ADDR, CONFIG_REG_DATA;
    logic        flag_timer, flag_interruptc, flag_remap_pause_controller, flag_slave4;
    logic [3:0]  burst_beats_left;
    logic [1:0]  HRESP;
    logic        HREADY_ERR;
    logic [3:0]  flags_w;

    int checks = 0;
    int errors = 0;

    bridge_ahb_slave_if dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA),
        .HREADY_IN(HREADY_IN), .valid(valid), .HWRITE_REG(HWRITE_REG),
        .HSIZE_REG(HSIZE_REG), .HADDR_REG_D1(HADDR_REG_D1), .HADDR_REG_D2(HADDR_REG_D2),
        .HADDR_REG_D3(HADDR_REG_D3), .HWDATA_REG(HWDATA_REG), .INC_ADDR(INC_ADDR),
        .CONFIG_REG_DATA(CONFIG_REG_DATA), .flag_timer(flag_timer),
        .flag_interruptc(flag_interruptc),
        .flag_remap_pause_controller(flag_remap_pause_controller),
        .flag_slave4(flag_slave4), .burst_beats_left(burst_beats_left),
        .HRESP(HRESP), .HREADY_ERR(HREADY_ERR)
    );

    assign flags_w = {flag_slave4, flag_remap_pause_controller, flag_interruptc, flag_timer};

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic        hsel;
        logic [31:0] haddr;
        logic [1:0]  htrans;
        logic        hwrite;
        logic [2:0]  hsize;
        logic [2:0]  hburst;
        logic [31:0] hwdata;
        logic        hready;
    } stim_t;

    typedef struct {
        logic        hsel;
        logic [31:0] haddr;
        logic [1:0]  htrans;
        logic        hready;
        logic        exp_valid;
        logic [3:0]  exp_flags;
        logic        exp_err;
    } vec_t;

    // Reference model state: what each output should read after the last edge
    int          m_err;
    logic [31:0] m_d1, m_d2, m_d3, m_wdata, m_cfg;
    logic        m_hwrite;
    logic [2:0]  m_size, m_burst;
    logic [3:0]  m_flags;
    int          m_rem;
    logic        m_wpend, m_cpend;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic f_mapped(input logic [31:0] a);
        return (a <= 32'd8) || (a[15:12] >= 4'd1 && a[15:12] <= 4'd4);
    endfunction

    function automatic logic [3:0] f_flags(input logic [31:0] a);
        if (a[15:12] >= 4'd1 && a[15:12] <= 4'd4) return 4'b0001 << (a[15:12] - 4'd1);
        return 4'b0000;
    endfunction

    function automatic int f_len(input logic [2:0] b);
        case (b)
            3'd2, 3'd3: return 4;
            3'd4, 3'd5: return 8;
            3'd6, 3'd7: return 16;
            default:    return 1;
        endcase
    endfunction

    // Next beat address: wrap bursts stay inside their len*bytes aligned block
    function automatic logic [31:0] f_inc(input logic [31:0] d1, input logic [2:0] size,
                                          input logic [2:0] burst);
        longint unsigned bytes, blk, off, base;
        bytes = 64'd1 << size;
        if (burst == 3'd2 || burst == 3'd4 || burst == 3'd6) begin
            blk  = longint'(f_len(burst)) * bytes;
            off  = {32'd0, d1} % blk;
            base = {32'd0, d1} - off;
            return 32'(base + (off + bytes) % blk);
        end
        return d1 + 32'(bytes);
    endfunction

    function automatic stim_t idle(input logic hready);
        stim_t s;
        s = '{1'b0, 32'd0, 2'b00, 1'b0, 3'd0, 3'd0, 32'd0, hready};
        return s;
    endfunction

    function automatic stim_t xfer(input logic [31:0] a, input logic [1:0] t, input logic w,
                                   input logic [2:0] b, input logic [31:0] d, input logic r);
        stim_t s;
        s = '{1'b1, a, t, w, 3'd2, b, d, r};
        return s;
    endfunction

    task automatic model_reset();
        m_err = 0; m_d1 = '0; m_d2 = '0; m_d3 = '0; m_wdata = '0; m_cfg = '0;
        m_hwrite = 1'b0; m_size = 3'd0; m_burst = 3'd0; m_flags = 4'd0; m_rem = 0;
        m_wpend = 1'b0; m_cpend = 1'b0;
    endtask

    task automatic drive(input stim_t s);
        HSEL = s.hsel; HADDR = s.haddr; HTRANS = s.htrans; HWRITE = s.hwrite;
        HSIZE = s.hsize; HBURST = s.hburst; HWDATA = s.hwdata; HREADY_IN = s.hready;
    endtask

    // Compare every output against the model, then advance the model by one edge
    task automatic model_cycle(input stim_t s);
        logic acc, map;
        int   nerr;
        acc = s.hsel && s.htrans[1] && s.hready;
        map = f_mapped(s.haddr);
        chk("m_valid", 32'(valid), 32'(acc && map && (m_err != 1)));
        chk("m_hwrite_reg", 32'(HWRITE_REG), 32'(m_hwrite));
        chk("m_hsize_reg", 32'(HSIZE_REG), 32'(m_size));
        chk("m_d1", HADDR_REG_D1, m_d1);
        chk("m_d2", HADDR_REG_D2, m_d2);
        chk("m_d3", HADDR_REG_D3, m_d3);
        chk("m_hwdata_reg", HWDATA_REG, m_wdata);
        chk("m_config", CONFIG_REG_DATA, m_cfg);
        chk("m_inc_addr", INC_ADDR, f_inc(m_d1, m_size, m_burst));
        chk("m_flags", 32'(flags_w), 32'(m_flags));
        chk("m_beats", 32'(burst_beats_left), 32'(m_rem));
        chk("m_hresp", 32'(HRESP), (m_err != 0) ? 32'd1 : 32'd0);
        chk("m_hready_err", 32'(HREADY_ERR), (m_err == 1) ? 32'd0 : 32'd1);
        if (s.hready) begin
            if (m_wpend) m_wdata = s.hwdata;
            if (m_cpend) m_cfg = s.hwdata;
        end
        nerr = (m_err == 1) ? 2 : ((acc && !map) ? 1 : 0);
        m_d3 = m_d2;
        m_d2 = m_d1;
        if (acc) begin
            m_d1 = s.haddr; m_hwrite = s.hwrite; m_size = s.hsize; m_burst = s.hburst;
            m_flags = f_flags(s.haddr);
            if (s.htrans == 2'b10) m_rem = f_len(s.hburst) - 1;
            else if (m_rem > 0) m_rem = m_rem - 1;
        end
        if (s.hready) begin
            m_wpend = acc && s.hwrite;
            m_cpend = acc && s.hwrite && (s.haddr == 32'h0000_0004);
        end
        m_err = nerr;
    endtask

    task automatic apply(input stim_t s);
        @(negedge HCLK);
        drive(s);
        #1;
        model_cycle(s);
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            apply(idle((m_err == 1) ? 1'b0 : 1'b1));
            tick();
        end
    endtask

    task automatic async_reset();
        #2;
        drive(idle(1'b1));
        HRESETn = 1'b0;
        #1;
        chk("rst_beats", 32'(burst_beats_left), 32'd0);
        chk("rst_flags", 32'(flags_w), 32'd0);
        chk("rst_hresp", 32'(HRESP), 32'd0);
        chk("rst_hready_err", 32'(HREADY_ERR), 32'd1);
        chk("rst_d1", HADDR_REG_D1, 32'd0);
        model_reset();
        @(negedge HCLK);
        #1 HRESETn = 1'b1;
    endtask

    vec_t  vecs[14];
    stim_t s;

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_1004, 2'b10, 1'b1, 1'b1, 4'b0001, 1'b0};
        vecs[1]  = '{1'b1, 32'h0000_2000, 2'b11, 1'b1, 1'b1, 4'b0010, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_3FFC, 2'b10, 1'b1, 1'b1, 4'b0100, 1'b0};
        vecs[3]  = '{1'b1, 32'h0000_4000, 2'b10, 1'b1, 1'b1, 4'b1000, 1'b0};
        vecs[4]  = '{1'b0, 32'h0000_1000, 2'b10, 1'b1, 1'b0, 4'b1000, 1'b0};
        vecs[5]  = '{1'b1, 32'h0000_1000, 2'b00, 1'b1, 1'b0, 4'b1000, 1'b0};
        vecs[6]  = '{1'b1, 32'h0000_1000, 2'b01, 1'b1, 1'b0, 4'b1000, 1'b0};
        vecs[7]  = '{1'b1, 32'h0000_1000, 2'b10, 1'b0, 1'b0, 4'b1000, 1'b0};
        vecs[8]  = '{1'b1, 32'h0000_0008, 2'b10, 1'b1, 1'b1, 4'b0000, 1'b0};
        vecs[9]  = '{1'b1, 32'h0000_0009, 2'b10, 1'b1, 1'b0, 4'b0000, 1'b1};
        vecs[10] = '{1'b1, 32'h0000_5000, 2'b10, 1'b1, 1'b0, 4'b0000, 1'b1};
        vecs[11] = '{1'b1, 32'h0001_0000, 2'b11, 1'b1, 1'b0, 4'b0000, 1'b1};
        vecs[12] = '{1'b1, 32'h0000_0000, 2'b10, 1'b1, 1'b1, 4'b0000, 1'b0};
        vecs[13] = '{1'b1, 32'h0000_0FFC, 2'b10, 1'b1, 1'b0, 4'b0000, 1'b1};

        model_reset();
        drive(idle(1'b1));
        HRESETn = 1'b0;
        repeat (3) @(posedge HCLK);
        #1;
        chk("reset_hresp", 32'(HRESP), 32'd0);
        chk("reset_hready_err", 32'(HREADY_ERR), 32'd1);
        chk("reset_beats", 32'(burst_beats_left), 32'd0);
        chk("reset_config", CONFIG_REG_DATA, 32'd0);
        @(negedge HCLK);
        #1 HRESETn = 1'b1;

        // Decode/qualification table
        for (int i = 0; i < 14; i++) begin
            s = '{vecs[i].hsel, vecs[i].haddr, vecs[i].htrans, 1'b0, 3'd2, 3'd0, 32'd0,
                  vecs[i].hready};
            apply(s);
            chk($sformatf("tbl%0d_valid", i), 32'(valid), 32'(vecs[i].exp_valid));
            tick();
            chk($sformatf("tbl%0d_flags", i), 32'(flags_w), 32'(vecs[i].exp_flags));
            chk($sformatf("tbl%0d_hresp", i), 32'(HRESP), 32'(vecs[i].exp_err));
            chk($sformatf("tbl%0d_hready_err", i), 32'(HREADY_ERR), 32'(!vecs[i].exp_err));
            idle_cycles(2);
        end

        // Single write to the timer, pipeline delays and data capture
        apply(xfer(32'h0000_1004, 2'b10, 1'b1, 3'd0, 32'd0, 1'b1));
        chk("wr_valid", 32'(valid), 32'd1);
        tick();
        chk("wr_flag_timer", 32'(flag_timer), 32'd1);
        chk("wr_d1", HADDR_REG_D1, 32'h0000_1004);
        apply('{1'b0, 32'd0, 2'b00, 1'b0, 3'd0, 3'd0, 32'hDEAD_BEEF, 1'b1});
        tick();
        chk("wr_d2", HADDR_REG_D2, 32'h0000_1004);
        chk("wr_hwdata", HWDATA_REG, 32'hDEAD_BEEF);
        apply(idle(1'b1));
        tick();
        chk("wr_d3", HADDR_REG_D3, 32'h0000_1004);

        // WRAP4 word burst from 0x2008
        apply(xfer(32'h0000_2008, 2'b10, 1'b0, 3'd2, 32'd0, 1'b1));
        tick();
        chk("wrap_inc0", INC_ADDR, 32'h0000_200C);
        chk("wrap_beats0", 32'(burst_beats_left), 32'd3);
        chk("wrap_flag", 32'(flag_interruptc), 32'd1);
        apply(xfer(32'h0000_200C, 2'b11, 1'b0, 3'd2, 32'd0, 1'b1));
        tick();
        chk("wrap_inc1", INC_ADDR, 32'h0000_2000);
        chk("wrap_beats1", 32'(burst_beats_left), 32'd2);
        apply(xfer(32'h0000_2000, 2'b11, 1'b0, 3'd2, 32'd0, 1'b1));
        tick();
        chk("wrap_inc2", INC_ADDR, 32'h0000_2004);
        chk("wrap_beats2", 32'(burst_beats_left), 32'd1);
        apply(xfer(32'h0000_2004, 2'b11, 1'b0, 3'd2, 32'd0, 1'b1));
        tick();
        chk("wrap_beats3", 32'(burst_beats_left), 32'd0);

        // Config register write
        apply(xfer(32'h0000_0004, 2'b10, 1'b1, 3'd0, 32'd0, 1'b1));
        tick();
        chk("cfg_flags", 32'(flags_w), 32'd0);
        apply('{1'b0, 32'd0, 2'b00, 1'b0, 3'd0, 3'd0, 32'h5A5A_0001, 1'b1});
        tick();
        chk("cfg_data", CONFIG_REG_DATA, 32'h5A5A_0001);

        // Unmapped read, then an unmapped transfer chained from ERR2
        apply(xfer(32'h0000_9000, 2'b10, 1'b0, 3'd0, 32'd0, 1'b1));
        chk("err_valid", 32'(valid), 32'd0);
        tick();
        chk("err1_hresp", 32'(HRESP), 32'd1);
        chk("err1_hready", 32'(HREADY_ERR), 32'd0);
        apply(idle(1'b0));
        tick();
        chk("err2_hresp", 32'(HRESP), 32'd1);
        chk("err2_hready", 32'(HREADY_ERR), 32'd1);
        apply(xfer(32'h0000_9000, 2'b10, 1'b0, 3'd0, 32'd0, 1'b1));
        chk("err2_valid", 32'(valid), 32'd0);
        tick();
        chk("rerr1_hready", 32'(HREADY_ERR), 32'd0);
        apply(idle(1'b0));
        tick();
        apply(idle(1'b1));
        tick();
        chk("err_done_hresp", 32'(HRESP), 32'd0);

        // INCR4 with BUSY and two wait states
        apply(xfer(32'h0000_3000, 2'b10, 1'b1, 3'd3, 32'd0, 1'b1));
        tick();
        apply(xfer(32'h0000_3004, 2'b11, 1'b1, 3'd3, 32'h1111_1111, 1'b1));
        tick();
        chk("busy_beats0", 32'(burst_beats_left), 32'd2);
        for (int k = 0; k < 2; k++) begin
            apply(xfer(32'h0000_3008, 2'b01, 1'b1, 3'd3, 32'h2222_2222, 1'b0));
            chk("busy_valid", 32'(valid), 32'd0);
            tick();
            chk("busy_beats", 32'(burst_beats_left), 32'd2);
            chk("busy_hwdata", HWDATA_REG, 32'h1111_1111);
        end
        apply(xfer(32'h0000_3008, 2'b11, 1'b1, 3'd3, 32'h2222_2222, 1'b1));
        tick();
        chk("busy_resume_beats", 32'(burst_beats_left), 32'd1);
        chk("busy_resume_hwdata", HWDATA_REG, 32'h2222_2222);

        // Reset mid-WRAP4 burst, then reset in the first error cycle
        apply(xfer(32'h0000_1000, 2'b10, 1'b0, 3'd2, 32'd0, 1'b1));
        tick();
        apply(xfer(32'h0000_1004, 2'b11, 1'b0, 3'd2, 32'd0, 1'b1));
        tick();
        async_reset();
        apply(xfer(32'h0000_7000, 2'b10, 1'b0, 3'd7, 32'd0, 1'b1));
        tick();
        async_reset();

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            s.hsel   = ($urandom_range(0, 7) != 0);
            s.htrans = 2'($urandom_range(0, 3));
            s.hwrite = 1'($urandom_range(0, 1));
            s.hsize  = 3'($urandom_range(0, 2));
            s.hburst = 3'($urandom_range(0, 7));
            s.hwdata = $urandom;
            case ($urandom_range(0, 5))
                0:       s.haddr = 32'($urandom_range(0, 12));
                1:       s.haddr = {16'($urandom), 4'($urandom_range(1, 4)), 12'($urandom)};
                2, 3, 4: s.haddr = {16'h0000, 4'($urandom_range(1, 4)), 12'($urandom)};
                default: s.haddr = $urandom;
            endcase
            s.hready = (m_err == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
            apply(s);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
